// File: rtl/mem_io_responder_pkg.sv
// Shared constants, IO register decode and status-byte packing for the
// byte-serial memory responder.
package mem_io_responder_pkg;

    localparam logic [1:0]  IO_SEL_BITS  = 2'b11;      // mem_a[17:16] selects the IO window
    localparam logic [31:0] IO_UART_DATA = 32'h30000;
    localparam logic [31:0] IO_STATUS    = 32'h30004;

    localparam int STATUS_RX_NONEMPTY = 0;
    localparam int STATUS_TX_FULL     = 1;

    // What a given bus address targets this cycle
    typedef enum logic [1:0] {
        REG_RAM    = 2'd0,
        REG_DATA   = 2'd1,
        REG_STATUS = 2'd2,
        REG_OTHER  = 2'd3
    } io_reg_e;

    // Full-address match inside the IO window; anything else in the window is a hole
    function automatic io_reg_e io_decode(input logic [31:0] a);
        if (a[17:16] != IO_SEL_BITS) return REG_RAM;
        if (a == IO_UART_DATA)       return REG_DATA;
        if (a == IO_STATUS)          return REG_STATUS;
        return REG_OTHER;
    endfunction

    function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_nonempty);
        logic [7:0] s;
        s = 8'h00;
        s[STATUS_TX_FULL]     = tx_full;
        s[STATUS_RX_NONEMPTY] = rx_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Small synchronous byte FIFO with combinational head; push is ignored when
// full and pop is ignored when empty, so an empty FIFO never forwards.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage array, no reset: contents are only meaningful under count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM with one-cycle read latency plus an IO
// window holding UART TX/RX FIFOs, a status register and a halt port.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_full,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    io_reg_e               reg_sel;

    logic [31:0]           prev_a;
    logic                  prev_wr;
    logic                  rd_first;

    logic                  tx_push;
    logic                  tx_full;
    logic [TX_CW-1:0]      tx_count;

    logic                  rx_pop;
    logic                  rx_nonempty;
    logic [7:0]            rx_head;
    logic [RX_CW-1:0]      rx_count;

    assign ram_idx  = mem_a[ADDR_WIDTH-1:0];
    assign reg_sel  = io_decode(mem_a);

    // The controller parks mem_a while idle, so only a fresh access may pop RX
    assign rd_first = (mem_a != prev_a) || prev_wr;

    assign tx_push     = (reg_sel == REG_DATA) && mem_wr;
    assign tx_valid    = (tx_count != '0);
    assign rx_nonempty = (rx_count != '0);
    assign rx_pop      = (reg_sel == REG_DATA) && !mem_wr && rd_first && rx_nonempty;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (mem_dout),
        .pop   (tx_ready),
        .head  (tx_data),
        .count (tx_count),
        .full  (tx_full)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full)
    );

    // RAM write port; IO-window stores never touch RAM, and RAM is not cleared on reset
    always_ff @(posedge clk) begin
        if (mem_wr && (reg_sel == REG_RAM)) ram[ram_idx] <= mem_dout;
    end

    // Read data register: RAM byte or IO value, visible the cycle after the address
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din <= 8'h00;
        end else begin
            case (reg_sel)
                REG_RAM:    mem_din <= ram[ram_idx];
                REG_DATA: begin
                    if (mem_wr)        mem_din <= 8'h00;
                    else if (rd_first) mem_din <= rx_nonempty ? rx_head : 8'h00;
                    // a held UART read keeps the byte it already returned
                end
                REG_STATUS: mem_din <= mem_wr ? 8'h00 : status_byte(tx_full, rx_nonempty);
                default:    mem_din <= 8'h00;
            endcase
        end
    end

    // Access-edge tracking, sticky flags and the lagged TX-nearly-full indication
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_a         <= 32'h0;
            prev_wr        <= 1'b0;
            halt           <= 1'b0;
            tx_overflow    <= 1'b0;
            io_buffer_full <= 1'b0;
        end else begin
            prev_a         <= mem_a;
            prev_wr        <= mem_wr;
            io_buffer_full <= (tx_count >= TX_CW'(TX_DEPTH - FULL_MARGIN));
            if (mem_wr && (reg_sel == REG_STATUS)) halt <= 1'b1;
            if (tx_push && tx_full)                tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM streaming, TX backpressure and
// overflow, RX pop-once semantics, status/halt decode, and mid-run reset.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_full;
    logic        halt;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_full        (rx_full),
        .halt           (halt),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, clock, then sample 1ns after the edge
    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        cyc(32'h0, 1'b0, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_ibf", io_buffer_full, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_full", rx_full, 0);
        chk("rst_halt", halt, 0);
        chk("rst_tx_ovf", tx_overflow, 0);
        rst = 1'b0;

        // RAM streaming writes then reads
        cyc(32'h100, 1'b1, 8'h11);
        cyc(32'h101, 1'b1, 8'h22);
        cyc(32'h102, 1'b1, 8'h33);
        cyc(32'h103, 1'b1, 8'h44);
        cyc(32'h0,     1'b1, 8'h99);
        cyc(32'h10008, 1'b1, 8'hAB);
        cyc(32'h100, 1'b0, 8'h00); chk("ram_rd_100", mem_din, 32'h11);
        cyc(32'h101, 1'b0, 8'h00); chk("ram_rd_101", mem_din, 32'h22);
        cyc(32'h102, 1'b0, 8'h00); chk("ram_rd_102", mem_din, 32'h33);
        cyc(32'h103, 1'b0, 8'h00); chk("ram_rd_103", mem_din, 32'h44);
        cyc(32'h200, 1'b1, 8'h5C);
        cyc(32'h200, 1'b0, 8'h00); chk("ram_raw", mem_din, 32'h5C);

        // TX backpressure and overflow with UART stalled
        for (int i = 0; i < 6; i++) cyc(32'h30000, 1'b1, 8'h41);
        chk("tx_ibf_lag", io_buffer_full, 0);
        chk("tx_valid_6", tx_valid, 1);
        cyc(32'h30000, 1'b1, 8'h41); chk("tx_ibf_rise", io_buffer_full, 1);
        cyc(32'h30000, 1'b1, 8'h41); chk("tx_ovf_at8", tx_overflow, 0);
        cyc(32'h30000, 1'b1, 8'h41); chk("tx_ovf_at9", tx_overflow, 1);
        cyc(32'h30004, 1'b0, 8'h00); chk("status_txfull", mem_din, 32'h02);
        tx_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (tx_valid) begin
                chk("tx_drain_data", tx_data, 32'h41);
                n++;
            end
            cyc(32'h0, 1'b0, 8'h00);
        end
        tx_ready = 1'b0;
        chk("tx_drain_count", n, 8);
        chk("tx_ibf_fall", io_buffer_full, 0);
        chk("tx_empty", tx_valid, 0);
        chk("tx_ovf_sticky", tx_overflow, 1);

        // RX: a held read pops exactly once
        rx_valid = 1'b1; rx_data = 8'h5A; cyc(32'h0, 1'b0, 8'h00);
        rx_data = 8'h5B;                  cyc(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        cyc(32'h30000, 1'b0, 8'h00); chk("rx_pop_first", mem_din, 32'h5A);
        cyc(32'h30000, 1'b0, 8'h00);
        cyc(32'h30000, 1'b0, 8'h00); chk("rx_pop_held", mem_din, 32'h5A);
        cyc(32'h30004, 1'b0, 8'h00); chk("status_rxne", mem_din, 32'h01);
        cyc(32'h30000, 1'b0, 8'h00); chk("rx_pop_second", mem_din, 32'h5B);
        cyc(32'h30004, 1'b0, 8'h00); chk("status_idle", mem_din, 32'h00);
        cyc(32'h30000, 1'b0, 8'h00); chk("rx_empty_rd", mem_din, 32'h00);

        // RX fill to full; the extra push is ignored
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h80 + 8'(i);
            cyc(32'h0, 1'b0, 8'h00);
        end
        chk("rx_full_set", rx_full, 1);
        rx_data = 8'hEE; cyc(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        cyc(32'h30000, 1'b0, 8'h00); chk("rx_full_head", mem_din, 32'h80);
        chk("rx_full_clr", rx_full, 0);

        // Halt and decode holes
        cyc(32'h30004, 1'b1, 8'h00); chk("halt_set", halt, 1);
        cyc(32'h30008, 1'b1, 8'h77); chk("halt_sticky", halt, 1);
        chk("hole_no_tx", tx_valid, 0);
        cyc(32'h30008, 1'b0, 8'h00); chk("hole_rd", mem_din, 32'h00);
        cyc(32'h10008, 1'b0, 8'h00); chk("hole_no_ram", mem_din, 32'hAB);
        cyc(32'h0,     1'b0, 8'h00); chk("ram0_kept", mem_din, 32'h99);

        // Reset mid-activity
        for (int i = 0; i < 3; i++) cyc(32'h30000, 1'b1, 8'h41);
        chk("pre_rst_txv", tx_valid, 1);
        rst = 1'b1;
        cyc(32'h30000, 1'b0, 8'h00);
        rst = 1'b0;
        chk("mid_rst_txv", tx_valid, 0);
        chk("mid_rst_halt", halt, 0);
        chk("mid_rst_ibf", io_buffer_full, 0);
        chk("mid_rst_ovf", tx_overflow, 0);
        chk("mid_rst_din", mem_din, 0);
        cyc(32'h30000, 1'b0, 8'h00); chk("mid_rst_rx_gone", mem_din, 32'h00);
        cyc(32'h100,   1'b0, 8'h00); chk("mid_rst_ram", mem_din, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
